// File: rtl/noc_push_arbiter.sv
// -----------------------------------------------------------------------------
// noc_push_arbiter
//
// Shares one NoC-bound push channel between NUM_REQ CPU-side valid/ready
// streams. Arbitration is round-robin starting after the last requester served.
// A grant lasts at most MAX_BURST accepted beats. Every output beat is tagged
// with the index of the requester that produced it.
//
// Handshake rules, which apply to both sides: a beat moves on a clock edge
// where valid and ready are both high. A source holds valid and data stable
// until that edge. Ready is allowed to depend on valid. Valid must never
// depend on ready.
//
// Ports:
//   clk      - single clock, all logic on posedge
//   rst      - synchronous, active-high reset
//   req_vld  - per-requester valid
//   req_rdy  - per-requester ready (at most one bit high; combinational)
//   req_data - requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_vld  - registered output valid
//   out_rdy  - downstream ready
//   out_data - registered output payload
//   out_src  - registered source index of out_data
//   busy     - high while the FSM is in GRANT (this is the FSM state bit)
// -----------------------------------------------------------------------------
module noc_push_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 64,
  parameter int  MAX_BURST  = 4,
  localparam int SRC_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]              out_src,
  output logic                          busy
);

  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                r_state;
  logic [SRC_W-1:0]      r_grant;
  logic [SRC_W-1:0]      r_last_grant;
  logic [CNT_W-1:0]      r_burst_cnt;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SRC_W-1:0]      r_out_src;

  state_t                w_state_nxt;
  logic [SRC_W-1:0]      w_grant_nxt;
  logic [SRC_W-1:0]      w_last_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  logic                  w_slot_free;
  logic                  w_grant_vld;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_grant_data;
  logic                  w_pick_vld;
  logic [SRC_W-1:0]      w_pick;
  logic [SRC_W-1:0]      w_cand;

  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Handshake with the granted requester. The output slot can take a new
  // beat when it is empty or is being drained in this same cycle.
  always_comb begin
    w_slot_free  = !r_out_vld || out_rdy;
    w_grant_vld  = req_vld[r_grant];
    w_grant_data = w_req_data[r_grant];
    w_accept     = (r_state == ST_GRANT) && w_slot_free && w_grant_vld;
    req_rdy      = '0;
    if ((r_state == ST_GRANT) && w_slot_free) begin
      req_rdy[r_grant] = 1'b1;
    end
  end

  // Round-robin pick. Walk the offsets from farthest to nearest so that the
  // last hit is the first valid requester after r_last_grant.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = SRC_W'((int'(r_last_grant) + k) % NUM_REQ);
      if (req_vld[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_cand;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    w_cnt_nxt   = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_accept) begin
          w_cnt_nxt = r_burst_cnt + 1'b1;
        end
        // A grant ends when the burst limit is reached, or when the slot
        // could take a beat but the owner has none. Backpressure alone never
        // ends a grant.
        if ((w_accept && (r_burst_cnt == LAST_CNT)) ||
            (w_slot_free && !w_grant_vld)) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= SRC_W'(NUM_REQ - 1);
      r_burst_cnt  <= '0;
      r_out_vld    <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      // A drain and a refill in the same cycle leave no bubble.
      if (w_accept) begin
        r_out_vld  <= 1'b1;
        r_out_data <= w_grant_data;
        r_out_src  <= r_grant;
      end else if (out_rdy) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

  assign out_vld  = r_out_vld;
  assign out_data = r_out_data;
  assign out_src  = r_out_src;
  assign busy     = (r_state == ST_GRANT);

endmodule

// File: tb/tb_noc_push_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_push_arbiter
//
// Bench for noc_push_arbiter. The main instance uses NUM_REQ=4 and
// MAX_BURST=4. A second instance uses MAX_BURST=1 with static inputs.
// The model is an in-order queue of accepted beats, checked on every cycle.
// Rule checks cover one-hot ready, ready under backpressure, burst length,
// and the bubble required between grants. Directed scenarios compare the
// logged output sequence against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_noc_push_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int MB  = 4;
  localparam int SW  = 2;
  localparam int DW2 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic [NR-1:0]    req_vld;
  logic [NR-1:0]    req_rdy;
  logic [NR*DW-1:0] req_data;
  logic             out_vld;
  logic             out_rdy;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    out_src;
  logic             busy;

  noc_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_data(req_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_src(out_src), .busy(busy)
  );

  // ---------------- MAX_BURST=1 DUT ----------------
  logic [NR-1:0]     req_vld2;
  logic [NR-1:0]     req_rdy2;
  logic [NR*DW2-1:0] req_data2;
  logic              out_vld2;
  logic              out_rdy2;
  logic [DW2-1:0]    out_data2;
  logic [SW-1:0]     out_src2;
  logic              busy2;

  noc_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW2), .MAX_BURST(1)) dut2 (
    .clk(clk), .rst(rst2), .req_vld(req_vld2), .req_rdy(req_rdy2),
    .req_data(req_data2), .out_vld(out_vld2), .out_rdy(out_rdy2),
    .out_data(out_data2), .out_src(out_src2), .busy(busy2)
  );

  // ---------------- bookkeeping ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0]    src_q [NR][$];
  logic [SW+DW-1:0] exp_q[$];
  int               log_cyc[$];
  logic [SW-1:0]    log_src[$];
  logic [DW-1:0]    log_data[$];
  int               log2_cyc[$];
  logic [SW-1:0]    log2_src[$];
  logic [DW2-1:0]   log2_data[$];
  logic [NR-1:0]    acc_mask;
  int               last_acc_cyc = -10;
  logic [SW-1:0]    last_acc_src = '0;
  int               run_len      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_vld[i] = (src_q[i].size() != 0);
      req_data[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc_mask[i]) void'(src_q[i].pop_front());
    end
    acc_mask = '0;
    drive();
  endtask

  task automatic log_clear();
    log_cyc.delete();
    log_src.delete();
    log_data.delete();
  endtask

  // ---------------- scoreboard / per-cycle compare ----------------
  always @(negedge clk) begin : mon
    logic [SW+DW-1:0] front;
    acc_mask = '0;
    if (rst) begin
      exp_q.delete();
      run_len      = 0;
      last_acc_cyc = -10;
    end else begin
      check("out_vld_vs_model", {63'd0, out_vld}, {63'd0, exp_q.size() != 0});
      if (out_vld && exp_q.size() != 0) begin
        front = exp_q[0];
        check("out_src_vs_model", 64'(out_src), 64'(front[DW +: SW]));
        check("out_data_vs_model", out_data, front[DW-1:0]);
        if (out_rdy) begin
          void'(exp_q.pop_front());
          log_cyc.push_back(cyc);
          log_src.push_back(out_src);
          log_data.push_back(out_data);
        end
      end
      check("req_rdy_onehot0", {63'd0, $countones(req_rdy) <= 1}, 64'd1);
      if (out_vld && !out_rdy) check("req_rdy_backpressure", 64'(req_rdy), 64'd0);
      acc_mask = req_vld & req_rdy;
      for (int i = 0; i < NR; i++) begin
        if (acc_mask[i]) begin
          exp_q.push_back({SW'(i), req_data[i*DW +: DW]});
          if (last_acc_cyc == cyc - 1) begin
            check("grant_switch_bubble", 64'(last_acc_src), 64'(i));
            run_len++;
          end else begin
            run_len = 1;
          end
          check("burst_len_limit", {63'd0, run_len <= MB}, 64'd1);
          last_acc_cyc = cyc;
          last_acc_src = SW'(i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst2 && out_vld2 && log2_cyc.size() < 8) begin
      log2_cyc.push_back(cyc);
      log2_src.push_back(out_src2);
      log2_data.push_back(out_data2);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int t0;
    int exp_s;
    int exp_c[6];
    rst       = 1'b1;
    rst2      = 1'b1;
    out_rdy   = 1'b1;
    out_rdy2  = 1'b1;
    req_vld   = '0;
    req_data  = '0;
    req_vld2  = 4'b1001;
    req_data2 = {8'hD3, 8'h22, 8'h11, 8'hA0};
    acc_mask  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", {63'd0, out_vld}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_req_rdy", 64'(req_rdy), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    rst  = 1'b0;
    rst2 = 1'b0;
    tick();
    tick();

    // Single requester: req 2 sends 0xA, 0xB, 0xC.
    log_clear();
    src_q[2].push_back(64'hA);
    src_q[2].push_back(64'hB);
    src_q[2].push_back(64'hC);
    drive();
    t0 = cyc;
    tick();
    check("single_busy_rise", {63'd0, busy}, 64'd1);
    #1;
    check("single_req_rdy", 64'(req_rdy), 64'h4);
    repeat (3) tick();
    check("single_busy_held", {63'd0, busy}, 64'd1);
    tick();
    check("single_busy_fall", {63'd0, busy}, 64'd0);
    tick();
    check("single_count", 64'(log_cyc.size()), 64'd3);
    for (int k = 0; k < 3 && k < log_cyc.size(); k++) begin
      check("single_src", 64'(log_src[k]), 64'd2);
      check("single_data", log_data[k], 64'(10 + k));
      check("single_cycle", 64'(log_cyc[k] - t0), 64'(2 + k));
    end

    // Full contention. last_grant is 2, so requester 3 goes first.
    log_clear();
    for (int s = 0; s < NR; s++) begin
      for (int j = 0; j < 12; j++) src_q[s].push_back(64'((s + 1) * 4096 + j));
    end
    drive();
    t0 = cyc;
    repeat (66) tick();
    check("contend_count", 64'(log_cyc.size()), 64'd48);
    if (log_cyc.size() != 0) check("contend_first_cycle", 64'(log_cyc[0] - t0), 64'd2);
    for (int k = 0; k < 48 && k < log_cyc.size(); k++) begin
      exp_s = (3 + k / 4) % 4;
      check("contend_src", 64'(log_src[k]), 64'(exp_s));
      check("contend_data", log_data[k], 64'((exp_s + 1) * 4096 + (k / 16) * 4 + k % 4));
      if (k > 0) check("contend_gap", 64'(log_cyc[k] - log_cyc[k-1]), (k % 4 == 0) ? 64'd2 : 64'd1);
    end

    // Backpressure: out_rdy low for 5 cycles while beat 1 sits in the output.
    log_clear();
    for (int j = 0; j < 6; j++) src_q[1].push_back(64'(176 + j));
    drive();
    t0 = cyc;
    repeat (3) tick();
    out_rdy = 1'b0;
    repeat (2) tick();
    #1;
    check("bp_req_rdy", 64'(req_rdy), 64'd0);
    check("bp_busy", {63'd0, busy}, 64'd1);
    check("bp_out_data", out_data, 64'hB1);
    check("bp_out_src", 64'(out_src), 64'd1);
    repeat (3) tick();
    out_rdy = 1'b1;
    repeat (7) tick();
    exp_c = '{2, 8, 9, 10, 12, 13};
    check("bp_count", 64'(log_cyc.size()), 64'd6);
    for (int k = 0; k < 6 && k < log_cyc.size(); k++) begin
      check("bp_src", 64'(log_src[k]), 64'd1);
      check("bp_data", log_data[k], 64'(176 + k));
      check("bp_cycle", 64'(log_cyc[k] - t0), 64'(exp_c[k]));
    end

    // Early release. A single beat from 0 first sets last_grant to 0.
    src_q[0].push_back(64'hC0);
    drive();
    repeat (5) tick();
    log_clear();
    for (int k = 0; k < 2; k++) begin
      src_q[0].push_back(64'(3584 + k));
      src_q[1].push_back(64'(3584 + 16 + k));
      src_q[2].push_back(64'(3584 + 32 + k));
    end
    drive();
    t0 = cyc;
    repeat (16) tick();
    exp_c = '{2, 3, 6, 7, 10, 11};
    check("early_count", 64'(log_cyc.size()), 64'd6);
    for (int k = 0; k < 6 && k < log_cyc.size(); k++) begin
      exp_s = (k < 2) ? 1 : (k < 4) ? 2 : 0;
      check("early_src", 64'(log_src[k]), 64'(exp_s));
      check("early_data", log_data[k], 64'(3584 + exp_s * 16 + k % 2));
      check("early_cycle", 64'(log_cyc[k] - t0), 64'(exp_c[k]));
    end

    // Reset mid-burst: rst is asserted while the 3rd beat from 3 is on the output.
    for (int j = 0; j < 6; j++) src_q[3].push_back(64'(240 + j));
    drive();
    t0 = cyc;
    repeat (4) tick();
    check("rstmid_beat3_src", 64'(out_src), 64'd3);
    check("rstmid_beat3_data", out_data, 64'hF2);
    rst = 1'b1;
    src_q[0].push_back(64'h50);
    src_q[0].push_back(64'h51);
    drive();
    tick();
    rst = 1'b0;
    log_clear();
    #1;
    check("rstmid_out_vld", {63'd0, out_vld}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_req_rdy", 64'(req_rdy), 64'd0);
    check("rstmid_out_src", 64'(out_src), 64'd0);
    repeat (15) tick();
    exp_c = '{7, 8, 11, 12, 13, 0};
    check("rstmid_count", 64'(log_cyc.size()), 64'd5);
    for (int k = 0; k < 5 && k < log_cyc.size(); k++) begin
      exp_s = (k < 2) ? 0 : 3;
      check("rstmid_src", 64'(log_src[k]), 64'(exp_s));
      check("rstmid_data", log_data[k], (k < 2) ? 64'(80 + k) : 64'(240 + k + 1));
      check("rstmid_cycle", 64'(log_cyc[k] - t0), 64'(exp_c[k]));
    end

    // MAX_BURST=1 with requesters 0 and 3 valid: 0,3,0,3 with a bubble between.
    check("mb1_count", 64'(log2_cyc.size()), 64'd8);
    for (int k = 0; k < 6 && k < log2_cyc.size(); k++) begin
      check("mb1_src", 64'(log2_src[k]), (k % 2 == 0) ? 64'd0 : 64'd3);
      check("mb1_data", 64'(log2_data[k]), (k % 2 == 0) ? 64'hA0 : 64'hD3);
      if (k > 0) check("mb1_gap", 64'(log2_cyc[k] - log2_cyc[k-1]), 64'd2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/noc_push_arbiter.md
# noc_push_arbiter

Round-robin arbiter that shares a single NoC-bound push channel between NUM_REQ CPU-side valid/ready streams. It sits between the per-CPU `data_cpu_to_noc` outputs and one `multisim_client_push` instance, so several CPUs can share one server connection. Each output beat is tagged with its source index. A per-grant burst limit bounds how long one CPU can hold the channel.

## Interface
- NUM_REQ, 4: number of requesters; must be ≥ 2.
- DATA_WIDTH, 64: payload width in bits.
- MAX_BURST, 4: maximum beats accepted per grant; must be ≥ 1.
- SRC_W, derived as max(1, $clog2(NUM_REQ)): width of the source tag.

Ports:
- clk, in, 1: single clock; all logic is on posedge clk.
- rst, in, 1: reset; synchronous, active-high.
- req_vld, in, NUM_REQ: per-requester valid.
- req_rdy, out, NUM_REQ: per-requester ready; at most one bit is high at any time.
- req_data, in, NUM_REQ*DATA_WIDTH: requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_vld, out, 1: registered output valid.
- out_rdy, in, 1: downstream ready.
- out_data, out, DATA_WIDTH: registered output payload.
- out_src, out, SRC_W: index of the requester that produced out_data.
- busy, out, 1: high while the FSM is in GRANT.

## Operation
- FSM has two states: IDLE and GRANT. Registers: grant (SRC_W), last_grant (SRC_W), burst_cnt ($clog2(MAX_BURST+1)), and the output register (out_vld, out_data, out_src).
- slot_free = !out_vld || out_rdy.
- req_rdy[i] = (state == GRANT) && (grant == i) && slot_free. This is combinational from registered state and out_rdy.
- accept = req_vld[grant] && req_rdy[grant].

IDLE:
- If any req_vld bit is high, select the first requester with req_vld high, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
- Load grant with that index, clear burst_cnt, and go to GRANT.
- If no req_vld bit is high, stay in IDLE.

GRANT:
- On accept: load out_data from req_data[grant], load out_src with grant, set out_vld=1, and increment burst_cnt.
- Return to IDLE and load last_grant with grant when either:
  - an accept happens with burst_cnt == MAX_BURST-1 (the burst limit is reached), or
  - slot_free is high and req_vld[grant] is low (the requester has no more data).
- Output register: if out_rdy is high and there is no accept, clear out_vld. If out_rdy is high and there is an accept, load the new beat in the same cycle with no bubble.
- While out_vld=1 and out_rdy=0, out_data and out_src hold stable.
- Backpressure (slot_free=0) never ends a grant and never increments burst_cnt.
- A requester that lowers req_vld while slot_free=0 keeps the grant. The grant ends on the first cycle with slot_free=1 in which req_vld[grant] is still low.

Reset (rst=1 at a posedge): state=IDLE, out_vld=0, out_data=0, out_src=0, req_rdy=0, busy=0, grant=0, burst_cnt=0, last_grant=NUM_REQ-1 (so requester 0 has first priority). A beat held in the output register when reset arrives is dropped.

## Timing
- Arbitration takes 1 cycle. If req_vld[i] rises in IDLE at cycle t, then req_rdy[i] is high at t+1 provided slot_free. The first beat appears on out_vld/out_data at t+2.
- Within a grant, throughput is 1 beat/cycle while out_rdy=1.
- Switching grants costs exactly one IDLE cycle. With continuous demand, the pattern is MAX_BURST beats followed by 1 bubble.
- out_vld, out_data, out_src and busy are registered outputs. req_rdy is the only combinational output, and it depends on out_rdy.
- A requester that stays in IDLE contention waits at most (NUM_REQ-1)*(MAX_BURST+1)+1 cycles for a grant, provided out_rdy is held at 1.

## Test plan
- Single requester: req 2 sends 3 beats (0xA,0xB,0xC) back-to-back with out_rdy=1 → the 3 beats appear on cycles t+2..t+4 with out_src=2. After the last beat, one cycle with req_vld[2]=0 returns the FSM to IDLE; busy then falls and last_grant=2.
- Full contention: all 4 requesters valid continuously, MAX_BURST=4, out_rdy=1 → out_src sequence is 0×4, 1×4, 2×4, 3×4, 0×4…, with exactly 1 bubble between bursts. The data sequence is in-order per source.
- Backpressure: out_rdy=0 for 5 cycles mid-burst → out_data/out_src stay stable, req_rdy is all zeros, and burst_cnt is unchanged. When out_rdy returns, the burst resumes with no loss and no duplication.
- Early release: req 1 offers 2 beats then drops vld → the grant ends after 2 beats, and the next grant goes to requester 2 (not requester 0), even though 0 and 2 are both valid.
- Reset mid-burst: assert rst during the 3rd beat of a burst → the next cycle shows out_vld=0, req_rdy=0, busy=0. After reset deasserts, requester 0 wins first.
- MAX_BURST=1 with requesters 0 and 3 both valid → out_src alternates 0,3,0,3 with a bubble between each beat.
